// File: rtl/tl_cntr_param.sv
// Timed two-road traffic light controller with latched left-turn requests,
// min/max main green, all-red clearance phases and a night flashing mode.
// Lamp encoding on La/Lb: 00 green, 01 yellow, 10 left arrow, 11 red.
module tl_cntr_param #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 8,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned LEFT_T    = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned FLASH_T   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       Tal,
  input  logic       Tbl,
  input  logic       flash,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_AG  = 4'd0,
    S_AY  = 4'd1,
    S_AL  = 4'd2,
    S_ALY = 4'd3,
    S_AR  = 4'd4,
    S_BG  = 4'd5,
    S_BY  = 4'd6,
    S_BL  = 4'd7,
    S_BLY = 4'd8,
    S_BR  = 4'd9,
    S_FL  = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    L_GREEN  = 2'b00,
    L_YELLOW = 2'b01,
    L_LEFT   = 2'b10,
    L_RED    = 2'b11
  } lamp_t;

  // Terminal counts (duration - 1) for each kind of phase.
  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LEFT_M1 = CNT_W'(LEFT_T - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FL_M1   = CNT_W'(FLASH_T - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] dur_m1;
  logic             req_al, req_al_nx;
  logic             req_bl, req_bl_nx;
  logic             flash_ph, flash_ph_nx;
  logic             fl_toggle;
  lamp_t            lamp_a, lamp_b;

  // State, timer, left-request latches and flash phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_AG;
      cnt      <= '0;
      req_al   <= 1'b0;
      req_bl   <= 1'b0;
      flash_ph <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      req_al   <= req_al_nx;
      req_bl   <= req_bl_nx;
      flash_ph <= flash_ph_nx;
    end
  end

  // Saturation limit of the timer for the current phase.
  always_comb begin
    dur_m1 = '0;
    case (state)
      S_AG, S_BG:                 dur_m1 = GMAX_M1;
      S_AY, S_ALY, S_BY, S_BLY:   dur_m1 = YEL_M1;
      S_AL, S_BL:                 dur_m1 = LEFT_M1;
      S_AR, S_BR:                 dur_m1 = AR_M1;
      S_FL:                       dur_m1 = FL_M1;
      default:                    dur_m1 = '0;
    endcase
  end

  // Next-state decision for the phase sequencer.
  always_comb begin
    state_nx  = state;
    fl_toggle = 1'b0;
    case (state)
      S_AG:  if (cnt >= GMIN_M1 && (!Ta || cnt == GMAX_M1)) state_nx = S_AY;
      S_AY:  if (cnt == YEL_M1) state_nx = req_al ? S_AL : S_AR;
      S_AL:  if (cnt == LEFT_M1) state_nx = S_ALY;
      S_ALY: if (cnt == YEL_M1) state_nx = S_AR;
      S_AR:  if (cnt == AR_M1) state_nx = flash ? S_FL : S_BG;
      S_BG:  if (cnt >= GMIN_M1 && (!Tb || cnt == GMAX_M1)) state_nx = S_BY;
      S_BY:  if (cnt == YEL_M1) state_nx = req_bl ? S_BL : S_BR;
      S_BL:  if (cnt == LEFT_M1) state_nx = S_BLY;
      S_BLY: if (cnt == YEL_M1) state_nx = S_BR;
      S_BR:  if (cnt == AR_M1) state_nx = flash ? S_FL : S_AG;
      S_FL: begin
        if (!flash)               state_nx  = S_BR;
        else if (cnt == FL_M1)    fl_toggle = 1'b1;
      end
      default:                    state_nx = S_AG;
    endcase
  end

  // Timer: restart on phase change or flash toggle, else count up to the limit.
  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state || fl_toggle) cnt_nx = '0;
    else if (cnt != dur_m1)             cnt_nx = cnt + 1'b1;
  end

  // Left-turn request latches and flash phase bookkeeping.
  // Ordering matters: set first, then clear on the left-phase entry edge and
  // on FL entry so that a clear always beats a simultaneous request.
  always_comb begin
    req_al_nx   = req_al;
    req_bl_nx   = req_bl;
    flash_ph_nx = flash_ph;
    if (Tal && state != S_AL && state != S_ALY) req_al_nx = 1'b1;
    if (Tbl && state != S_BL && state != S_BLY) req_bl_nx = 1'b1;
    if (state == S_AY && state_nx == S_AL)      req_al_nx = 1'b0;
    if (state == S_BY && state_nx == S_BL)      req_bl_nx = 1'b0;
    if (state != S_FL && state_nx == S_FL) begin
      req_al_nx = 1'b0;
      req_bl_nx = 1'b0;
    end
    if (fl_toggle)         flash_ph_nx = ~flash_ph;
    if (state_nx != S_FL)  flash_ph_nx = 1'b0;
  end

  // Moore lamp decode from the state register.
  always_comb begin
    lamp_a = L_RED;
    lamp_b = L_RED;
    case (state)
      S_AG:    lamp_a = L_GREEN;
      S_AY:    lamp_a = L_YELLOW;
      S_AL:    lamp_a = L_LEFT;
      S_ALY:   lamp_a = L_YELLOW;
      S_BG:    lamp_b = L_GREEN;
      S_BY:    lamp_b = L_YELLOW;
      S_BL:    lamp_b = L_LEFT;
      S_BLY:   lamp_b = L_YELLOW;
      S_FL: begin
        lamp_a = flash_ph ? L_RED : L_YELLOW;
        lamp_b = flash_ph ? L_RED : L_YELLOW;
      end
      default: begin
        lamp_a = L_RED;
        lamp_b = L_RED;
      end
    endcase
  end

  assign La      = lamp_a;
  assign Lb      = lamp_b;
  assign state_o = state;

endmodule
